// File: rtl/aftab_csr_access_ctrl.sv
// Sequencer for RISC-V Zicsr instructions: check the address, read the CSR, write it back and
// return the old value to rd. Every strobe is decoded from the state and is forced low by reset.
module aftab_csr_access_ctrl #(
    parameter int len = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startCSR,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csrAddr,
    input  logic [len-1:0]  rs1Data,
    input  logic [4:0]      uimm,
    input  logic            rdIsZero,
    input  logic            validAddressCSR,
    input  logic [len-1:0]  csrReadData,
    output logic [11:0]     addressRegBank,
    output logic            readRegBank,
    output logic            writeRegBank,
    output logic [len-1:0]  csrWriteData,
    output logic            rdWriteEn,
    output logic [len-1:0]  rdWriteData,
    output logic            busy,
    output logic            doneCSR,
    output logic            illegalInstr
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WRITE,
        DONE,
        ILLEGAL
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       opcode_q, opcode_d;
    logic [11:0]      addr_q, addr_d;
    logic             rdZero_q, rdZero_d;
    logic [len-1:0]   operand_q, operand_d;
    logic             srcZero_q, srcZero_d;
    logic [len-1:0]   oldValue_q, oldValue_d;

    logic             readStrobe, writeStrobe, rdStrobe, doneStrobe, illStrobe;
    logic             isRW;
    logic [len-1:0]   newOperand;

    assign isRW       = (opcode_q == 2'b01);
    assign newOperand = funct3[2] ? {{(len-5){1'b0}}, uimm} : rs1Data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= 2'b00;
            addr_q     <= 12'h000;
            rdZero_q   <= 1'b0;
            operand_q  <= '0;
            srcZero_q  <= 1'b0;
            oldValue_q <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            rdZero_q   <= rdZero_d;
            operand_q  <= operand_d;
            srcZero_q  <= srcZero_d;
            oldValue_q <= oldValue_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        rdZero_d    = rdZero_q;
        operand_d   = operand_q;
        srcZero_d   = srcZero_q;
        oldValue_d  = oldValue_q;
        readStrobe  = 1'b0;
        writeStrobe = 1'b0;
        rdStrobe    = 1'b0;
        doneStrobe  = 1'b0;
        illStrobe   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startCSR) begin
                    opcode_d  = funct3[1:0];
                    addr_d    = csrAddr;
                    rdZero_d  = rdIsZero;
                    operand_d = newOperand;
                    srcZero_d = (newOperand == '0);
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (!validAddressCSR || opcode_q == 2'b00) state_d = ILLEGAL;
                else                                      state_d = READ;
            end
            READ: begin
                // CSRRW(I) into x0 must not cause read side effects
                readStrobe = !(isRW && rdZero_q);
                oldValue_d = readStrobe ? csrReadData : '0;
                state_d    = WRITE;
            end
            WRITE: begin
                writeStrobe = isRW || !srcZero_q;
                rdStrobe    = !rdZero_q;
                state_d     = DONE;
            end
            DONE: begin
                doneStrobe = 1'b1;
                state_d    = IDLE;
            end
            ILLEGAL: begin
                doneStrobe = 1'b1;
                illStrobe  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        csrWriteData = '0;
        if (state_q == WRITE) begin
            unique case (opcode_q)
                2'b01:   csrWriteData = operand_q;
                2'b10:   csrWriteData = oldValue_q | operand_q;
                2'b11:   csrWriteData = oldValue_q & ~operand_q;
                default: csrWriteData = '0;
            endcase
        end
    end

    assign readRegBank    = readStrobe  && !rst;
    assign writeRegBank   = writeStrobe && !rst;
    assign rdWriteEn      = rdStrobe    && !rst;
    assign doneCSR        = doneStrobe  && !rst;
    assign illegalInstr   = illStrobe   && !rst;
    assign rdWriteData    = (state_q == WRITE) ? oldValue_q : '0;
    assign busy           = (state_q != IDLE);
    assign addressRegBank = (state_q == IDLE) ? 12'h000 : addr_q;

endmodule

// File: tb/tb_aftab_csr_access_ctrl.sv
// Scoreboard bench for aftab_csr_access_ctrl: each issued instruction queues the expected per-cycle
// outputs, and a checker pops and compares one entry every falling edge.
module tb_aftab_csr_access_ctrl;

    typedef struct packed {
        logic        busy;
        logic [11:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        rdEn;
        logic [31:0] rdData;
        logic        done;
        logic        ill;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startCSR = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [11:0] csrAddr = 12'h000;
    logic [31:0] rs1Data = 32'h0;
    logic [4:0]  uimm = 5'h0;
    logic        rdIsZero = 1'b0;
    logic        validAddressCSR = 1'b0;
    logic [31:0] csrReadData = 32'h0;
    logic [11:0] addressRegBank;
    logic        readRegBank, writeRegBank, rdWriteEn, busy, doneCSR, illegalInstr;
    logic [31:0] csrWriteData, rdWriteData;

    outs_t       expQ[$];
    string       tagQ[$];
    int          checks = 0;
    int          fails = 0;

    aftab_csr_access_ctrl #(.len(32)) dut (
        .clk(clk), .rst(rst), .startCSR(startCSR), .funct3(funct3), .csrAddr(csrAddr),
        .rs1Data(rs1Data), .uimm(uimm), .rdIsZero(rdIsZero), .validAddressCSR(validAddressCSR),
        .csrReadData(csrReadData), .addressRegBank(addressRegBank), .readRegBank(readRegBank),
        .writeRegBank(writeRegBank), .csrWriteData(csrWriteData), .rdWriteEn(rdWriteEn),
        .rdWriteData(rdWriteData), .busy(busy), .doneCSR(doneCSR), .illegalInstr(illegalInstr)
    );

    always #5 clk = ~clk;

    // Checker: one queued expectation per falling edge
    initial begin
        outs_t obs, exp;
        string tag;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                tag = tagQ.pop_front();
                obs = '{busy, addressRegBank, readRegBank, writeRegBank, csrWriteData,
                        rdWriteEn, rdWriteData, doneCSR, illegalInstr};
                checks++;
                assert (obs === exp) else begin
                    fails++;
                    $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
                end
            end
        end
    end

    function automatic outs_t idleOuts();
        return '0;
    endfunction

    task automatic pushExp(input outs_t e, input string tag);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s timeout observed=%0d pending expected=0", name, expQ.size());
            expQ.delete();
            tagQ.delete();
        end
    endtask

    // Issue one instruction right after a falling edge and queue its expected cycles
    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] rs1, input logic [4:0] imm, input logic rdZ,
                                 input logic valid, input logic [31:0] csrVal,
                                 input bit noise, input bit rstAtWrite);
        outs_t e;
        logic [31:0] op, old;
        logic isRW, srcZ, doRead;
        @(negedge clk);
        #1;
        funct3 = f3; csrAddr = addr; rs1Data = rs1; uimm = imm; rdIsZero = rdZ;
        validAddressCSR = valid; csrReadData = csrVal; startCSR = 1'b1;

        op     = f3[2] ? {27'b0, imm} : rs1;
        isRW   = (f3[1:0] == 2'b01);
        srcZ   = (op == 32'h0);
        doRead = !(isRW && rdZ);
        old    = doRead ? csrVal : 32'h0;

        e = '0; e.busy = 1'b1; e.addr = addr;
        pushExp(e, {name, ".check"});
        if (!valid || f3[1:0] == 2'b00) begin
            e.done = 1'b1; e.ill = 1'b1;
            pushExp(e, {name, ".illegal"});
        end else begin
            e.rd = doRead;
            pushExp(e, {name, ".read"});
            e.rd     = 1'b0;
            e.wr     = rstAtWrite ? 1'b0 : (isRW || !srcZ);
            e.rdEn   = rstAtWrite ? 1'b0 : !rdZ;
            e.rdData = old;
            case (f3[1:0])
                2'b01:   e.wdata = op;
                2'b10:   e.wdata = old | op;
                default: e.wdata = old & ~op;
            endcase
            pushExp(e, {name, ".write"});
            if (!rstAtWrite) begin
                e = '0; e.busy = 1'b1; e.addr = addr; e.done = 1'b1;
                pushExp(e, {name, ".done"});
            end
        end
        pushExp(idleOuts(), {name, ".idle"});

        @(posedge clk);
        #1;
        startCSR = 1'b0;
        if (noise) begin
            @(posedge clk);
            #1;
            startCSR = 1'b1; funct3 = 3'b011; csrAddr = 12'hABC; rs1Data = 32'hFFFF_FFFF;
            uimm = 5'h1F; rdIsZero = ~rdZ;
            @(posedge clk);
            #1;
            startCSR = 1'b0;
        end
        if (rstAtWrite) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        waitDrain(name);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        pushExp(idleOuts(), "reset.hold");
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pushExp(idleOuts(), "reset.after");
        waitDrain("reset");

        //              name        f3      addr     rs1            uimm   rdZ  valid csr            noise rstW
        applyStimulus("csrrw",    3'b001, 12'h305, 32'h0000_0100, 5'h00, 1'b0, 1'b1, 32'h0000_0000, 0, 0);
        applyStimulus("csrrs",    3'b010, 12'h300, 32'h0000_0008, 5'h00, 1'b0, 1'b1, 32'h0000_1800, 0, 0);
        applyStimulus("csrrsZero",3'b010, 12'h300, 32'h0000_0000, 5'h00, 1'b0, 1'b1, 32'h0000_1800, 0, 0);
        applyStimulus("csrrci",   3'b111, 12'h344, 32'hDEAD_BEEF, 5'h1F, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("badAddr",  3'b001, 12'h7C0, 32'h1234_5678, 5'h00, 1'b0, 1'b0, 32'h5555_5555, 0, 0);
        applyStimulus("badF3",    3'b100, 12'h300, 32'h0000_0001, 5'h00, 1'b0, 1'b1, 32'h0000_00FF, 0, 0);
        applyStimulus("rwToX0",   3'b001, 12'h340, 32'hCAFE_0001, 5'h00, 1'b1, 1'b1, 32'h0BAD_F00D, 0, 0);
        applyStimulus("rwiZero",  3'b101, 12'h341, 32'hFFFF_FFFF, 5'h00, 1'b0, 1'b1, 32'h0000_1234, 0, 0);
        applyStimulus("rsiZero",  3'b110, 12'h342, 32'hFFFF_FFFF, 5'h00, 1'b0, 1'b1, 32'h0000_00AA, 0, 0);
        applyStimulus("rc",       3'b011, 12'h304, 32'h0000_F0F0, 5'h00, 1'b0, 1'b1, 32'h1234_FFFF, 0, 0);
        applyStimulus("busyStart",3'b010, 12'h305, 32'h0000_0002, 5'h00, 1'b0, 1'b1, 32'h0000_0011, 1, 0);
        applyStimulus("rstWrite", 3'b001, 12'h306, 32'h0000_0077, 5'h00, 1'b0, 1'b1, 32'h0000_0033, 0, 1);
        applyStimulus("afterRst", 3'b110, 12'h300, 32'h0000_0000, 5'h04, 1'b0, 1'b1, 32'h0000_0001, 0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/aftab_csr_access_ctrl.md
AFTAB_CSR_ACCESS_CTRL -- requirements
Module: aftab_csr_access_ctrl

Interface
REQ-001 Parameter: len, 32, data width of CSR and register-file values.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 startCSR  in  1  one-cycle request to execute a CSR instruction.
REQ-006 funct3  in  3  CSR opcode: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-007 csrAddr  in  12  instruction CSR address field.
REQ-008 rs1Data  in  len  rs1 register value.
REQ-009 uimm  in  5  rs1 field used as the immediate.
REQ-010 rdIsZero  in  1  rd == x0.
REQ-011 validAddressCSR  in  1  address-checker verdict for addressRegBank.
REQ-012 csrReadData  in  len  CSR bank read data, combinational from addressRegBank.
REQ-013 addressRegBank  out  12  latched CSR address to checker and CSR bank.
REQ-014 readRegBank  out  1  CSR read strobe.
REQ-015 writeRegBank  out  1  CSR write strobe.
REQ-016 csrWriteData  out  len  value to write into the CSR.
REQ-017 rdWriteEn / rdWriteData  out  1 / len  register-file writeback of the old CSR value.
REQ-018 busy / doneCSR / illegalInstr  out  1 each  status, completion pulse, trap request.

Function
REQ-019 The FSM SHALL have states IDLE, CHECK, READ, WRITE, DONE and ILLEGAL; busy=1 in every state except IDLE.
REQ-020 IDLE: on startCSR=1, latch funct3, csrAddr and rdIsZero; latch operand = rs1Data, or {zeros,uimm} when funct3[2]=1; latch srcZero = (operand==0); go to CHECK.
REQ-021 startCSR SHALL be ignored in every state except IDLE.
REQ-022 addressRegBank SHALL equal the latched address in every state except IDLE, and 0 in IDLE.
REQ-023 CHECK: if validAddressCSR=0 or funct3[1:0]=00, go to ILLEGAL; otherwise go to READ.
REQ-024 READ: readRegBank=1 except for RW/RWI with rdIsZero=1; oldValue is latched from csrReadData, or 0 when the read is suppressed; go to WRITE.
REQ-025 WRITE: csrWriteData is operand for RW, oldValue|operand for RS, and oldValue&~operand for RC.
REQ-026 WRITE: writeRegBank=1 except for RS/RC(I) with srcZero=1.
REQ-027 WRITE: rdWriteEn=!rdIsZero and rdWriteData=oldValue; then go to DONE.
REQ-028 DONE: doneCSR=1 for one cycle; go to IDLE.
REQ-029 ILLEGAL: illegalInstr=1 and doneCSR=1 for one cycle, with no read, write or rd strobe; go to IDLE.
REQ-030 Latency from the startCSR cycle (n) SHALL be: valid access, doneCSR at n+4; illegal access, illegalInstr at n+2.
REQ-031 All strobes SHALL be decoded from the state only (Moore); each strobe SHALL be at most one cycle per instruction.
REQ-032 A new startCSR SHALL be accepted in the cycle after DONE or ILLEGAL, i.e. back-to-back at 5-cycle spacing.

Reset
REQ-033 rst=1 SHALL force the state to IDLE and clear the latched address, operand and oldValue to 0 on the next edge.
REQ-034 While rst=1, all strobes (readRegBank, writeRegBank, rdWriteEn, doneCSR, illegalInstr) SHALL be forced to 0 combinationally, including when rst rises in WRITE, so no partial write occurs.
REQ-035 After reset, all outputs SHALL be 0, busy=0 and addressRegBank=12'h000.

Verification
REQ-036 CSRRW 0x305, rs1Data=0x0000_0100, rd≠0, CSR=0x0000_0000 -> read at n+2; write 0x100 at n+3; rdWriteData=0 at n+3; doneCSR at n+4.
REQ-037 CSRRS 0x300, rs1Data=0x8, CSR=0x1800 -> csrWriteData=0x1808 and rdWriteData=0x1800; CSRRS with rs1Data=0 -> writeRegBank stays 0 and rd still gets 0x1800.
REQ-038 CSRRCI 0x344, uimm=5'h1F, CSR=0xFFFF_FFFF -> csrWriteData=0xFFFF_FFE0.
REQ-039 Access to 0x7C0 (validAddressCSR=0) -> illegalInstr=1 and doneCSR=1 at n+2; no read, write or rd strobe ever asserted.
REQ-040 startCSR pulsed while busy -> ignored, first instruction completes unchanged; rst=1 during WRITE -> writeRegBank=0 that cycle, state IDLE next cycle, busy=0.
